// File: rtl/wb_scoreboard.sv
// Register write scoreboard: issue marks rd pending, write-back clears it; stall outputs are combinational from state, updates land next cycle.
// Optional stall watchdog (sticky sb_timeout) is built only when SB_WATCHDOG_EN is defined.
module wb_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int CNT_W    = 2,
  parameter int WD_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_is_load,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic            stall_id,
  output logic            stall_load,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err,
  output logic            sb_timeout
);

  if (WD_LIMIT < 1 || WD_LIMIT > 127) begin : g_wd_limit_check
    $error("WD_LIMIT must fit the 7-bit stall counter");
  end

  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NREG-1:0]            ld, ld_nxt;
  logic                       h1, h2, sat;
  logic                       fire, retire, underflow;

  // Hazards look only at registered state: a same-cycle write-back is not bypassed.
  always_comb begin
    h1         = rs1_used && (rs1_addr != '0) && (cnt[rs1_addr] != '0);
    h2         = rs2_used && (rs2_addr != '0) && (cnt[rs2_addr] != '0);
    sat        = issue_valid && (issue_rd != '0) && (cnt[issue_rd] == '1);
    stall_id   = h1 || h2 || sat;
    stall_load = (h1 && ld[rs1_addr]) || (h2 && ld[rs2_addr]);
    fire       = issue_valid && !stall_id && (issue_rd != '0);
    retire     = wb_valid && (wb_rd != '0);
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Retire first, then let a same-register fire override it: net count is
  // unchanged, or 1 when the retire was an underflow.
  always_comb begin
    cnt_nxt   = cnt;
    ld_nxt    = ld;
    underflow = 1'b0;
    if (retire) begin
      if (cnt[wb_rd] == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_nxt[wb_rd] = cnt[wb_rd] - CNT_W'(1);
        if (cnt[wb_rd] == CNT_W'(1)) begin
          ld_nxt[wb_rd] = 1'b0;
        end
      end
    end
    if (fire) begin
      if (retire && (wb_rd == issue_rd)) begin
        cnt_nxt[issue_rd] = (cnt[issue_rd] == '0) ? CNT_W'(1) : cnt[issue_rd];
      end else begin
        cnt_nxt[issue_rd] = cnt[issue_rd] + CNT_W'(1);
      end
      ld_nxt[issue_rd] = issue_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      ld     <= '0;
      sb_err <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      ld  <= '0;
    end else begin
      cnt <= cnt_nxt;
      ld  <= ld_nxt;
      if (underflow) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef SB_WATCHDOG_EN
  localparam logic [6:0] WD_LIM = 7'(WD_LIMIT);
  logic [6:0] wd_cnt;

  // Counter saturates at the limit so a long stall can never wrap it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wd_cnt     <= '0;
      sb_timeout <= 1'b0;
    end else if (stall_id) begin
      if (wd_cnt != WD_LIM) begin
        wd_cnt <= wd_cnt + 7'd1;
      end
      if (wd_cnt + 7'd1 == WD_LIM) begin
        sb_timeout <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign sb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: stimulus queues expected outputs, a negedge monitor checks them.
module tb_wb_scoreboard;

  localparam logic [4:0] C_SID  = 5'b00001;
  localparam logic [4:0] C_SLD  = 5'b00010;
  localparam logic [4:0] C_BUSY = 5'b00100;
  localparam logic [4:0] C_ERR  = 5'b01000;
  localparam logic [4:0] C_TO   = 5'b10000;
  localparam logic [4:0] C_ALL  = 5'b11111;

  logic        clk, rst_n, flush;
  logic        issue_valid, issue_is_load, wb_valid, rs1_used, rs2_used;
  logic [4:0]  issue_rd, wb_rd, rs1_addr, rs2_addr;
  logic        stall_id, stall_load, sb_err, sb_timeout;
  logic [31:0] busy_vec;

  typedef struct {
    string       name;
    logic [4:0]  chk;
    logic        sid;
    logic        sld;
    logic [31:0] bmask;
    logic [31:0] bval;
    logic        err;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .stall_id(stall_id), .stall_load(stall_load), .busy_vec(busy_vec),
    .sb_err(sb_err), .sb_timeout(sb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_rd = 0; issue_is_load = 0;
    wb_valid = 0; wb_rd = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic expect_out(input string name, input logic [4:0] chk, input logic sid,
                            input logic sld, input logic [31:0] bmask, input logic [31:0] bval,
                            input logic err, input logic to);
    exp_t e;
    e.name = name; e.chk = chk; e.sid = sid; e.sld = sld;
    e.bmask = bmask; e.bval = bval; e.err = err; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // Monitor: outputs are valid every cycle; compare whatever was queued for it.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      bit   bad;
      e   = exp_q.pop_front();
      bad = 0;
      if (e.chk[0] && stall_id   !== e.sid) bad = 1;
      if (e.chk[1] && stall_load !== e.sld) bad = 1;
      if (e.chk[2] && ((busy_vec & e.bmask) !== e.bval)) bad = 1;
      if (e.chk[3] && sb_err     !== e.err) bad = 1;
      if (e.chk[4] && sb_timeout !== e.to)  bad = 1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got stall_id=%b stall_load=%b busy=%h err=%b timeout=%b; want(chk=%b) stall_id=%b stall_load=%b busy&%h=%h err=%b timeout=%b",
                 e.name, stall_id, stall_load, busy_vec, sb_err, sb_timeout,
                 e.chk, e.sid, e.sld, e.bmask, e.bval, e.err, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "time limit");
  end

  initial begin
    logic to_exp;
    rst_n = 0;
    idle();
    do_reset();

    // 1: after reset nothing is pending
    rs1_addr = 5; rs1_used = 1;
    expect_out("reset_state", C_ALL, 0, 0, '1, '0, 0, 0);
    step();

    // 2: non-load writer, no write-back bypass
    idle(); issue_valid = 1; issue_rd = 5;
    expect_out("issue5_fires", C_SID, 0, 0, '0, '0, 0, 0);
    step();
    idle(); rs1_addr = 5; rs1_used = 1;
    expect_out("raw5_stall", C_SID | C_SLD | C_BUSY, 1, 0, 32'h20, 32'h20, 0, 0);
    step();
    idle(); rs1_addr = 5; rs1_used = 1; wb_valid = 1; wb_rd = 5;
    expect_out("raw5_no_bypass", C_SID, 1, 0, '0, '0, 0, 0);
    step();
    idle(); rs1_addr = 5; rs1_used = 1;
    expect_out("raw5_cleared", C_SID | C_BUSY, 0, 0, '1, '0, 0, 0);
    step();

    // 3: load-use on rs2
    idle(); issue_valid = 1; issue_rd = 7; issue_is_load = 1;
    expect_out("issue7_load", C_SID, 0, 0, '0, '0, 0, 0);
    step();
    idle(); rs2_addr = 7; rs2_used = 1; wb_valid = 1; wb_rd = 7;
    expect_out("load_use7", C_SID | C_SLD | C_BUSY, 1, 1, 32'h80, 32'h80, 0, 0);
    step();
    idle(); rs2_addr = 7; rs2_used = 1;
    expect_out("load_use7_clear", C_SID | C_SLD | C_BUSY, 0, 0, '1, '0, 0, 0);
    step();

    // 4: three writers to x3 saturate the 2-bit counter
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1; issue_rd = 3;
      expect_out($sformatf("issue3_n%0d", i), C_SID, 0, 0, '0, '0, 0, 0);
      step();
    end
    idle(); issue_valid = 1; issue_rd = 3;
    expect_out("issue3_saturated", C_SID | C_SLD | C_BUSY, 1, 0, 32'h8, 32'h8, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid = 1; wb_rd = 3; rs1_addr = 3; rs1_used = 1;
      expect_out($sformatf("wb3_n%0d", i), C_SID | C_BUSY, 1, 0, 32'h8, 32'h8, 0, 0);
      step();
    end
    idle(); rs1_addr = 3; rs1_used = 1;
    expect_out("x3_drained", C_SID | C_BUSY | C_ERR, 0, 0, '1, '0, 0, 0);
    step();

    // Same-cycle fire+retire on a pending reg: count kept, load flag follows issue
    idle(); issue_valid = 1; issue_rd = 6; issue_is_load = 1;
    step();
    idle(); issue_valid = 1; issue_rd = 6; issue_is_load = 0; wb_valid = 1; wb_rd = 6;
    expect_out("fire_retire6", C_SID, 0, 0, '0, '0, 0, 0);
    step();
    idle(); rs1_addr = 6; rs1_used = 1;
    expect_out("x6_still_pending", C_SID | C_SLD | C_BUSY | C_ERR, 1, 0, 32'h40, 32'h40, 0, 0);
    step();
    idle(); wb_valid = 1; wb_rd = 6;
    step();
    idle();
    expect_out("x6_drained", C_BUSY | C_ERR, 0, 0, '1, '0, 0, 0);
    step();

    // Same-cycle fire+retire on an idle reg: underflow, count becomes 1
    idle(); issue_valid = 1; issue_rd = 10; wb_valid = 1; wb_rd = 10;
    step();
    idle();
    expect_out("fire_retire10_underflow", C_BUSY | C_ERR, 0, 0, 32'h400, 32'h400, 1, 0);
    step();
    do_reset();

    // 5: write-back underflow is sticky; x0 never counted
    idle(); wb_valid = 1; wb_rd = 9;
    expect_out("wb9_err_not_yet", C_ERR, 0, 0, '0, '0, 0, 0);
    step();
    idle();
    expect_out("wb9_err_set", C_ERR | C_BUSY, 0, 0, '1, '0, 1, 0);
    step();
    idle(); issue_valid = 1; issue_rd = 0; rs1_addr = 0; rs1_used = 1; wb_valid = 1; wb_rd = 0;
    expect_out("x0_issue", C_SID | C_BUSY, 0, 0, 32'h1, 32'h0, 0, 0);
    step();
    idle(); rs1_addr = 0; rs1_used = 1;
    expect_out("x0_never_busy", C_SID | C_BUSY | C_ERR, 0, 0, '1, '0, 1, 0);
    step();

    // 6: flush discards writers, keeps sb_err
    idle(); issue_valid = 1; issue_rd = 4;
    step();
    idle(); rs1_addr = 4; rs1_used = 1; flush = 1;
    expect_out("flush_cycle", C_SID | C_BUSY, 1, 0, 32'h10, 32'h10, 0, 0);
    step();
    idle(); rs1_addr = 4; rs1_used = 1;
    expect_out("after_flush", C_SID | C_BUSY | C_ERR, 0, 0, '1, '0, 1, 0);
    step();

    // Watchdog: hold the rs1=4 hazard
    idle(); issue_valid = 1; issue_rd = 4;
    step();
    for (int i = 0; i < 70; i++) begin
      idle(); rs1_addr = 4; rs1_used = 1;
`ifdef SB_WATCHDOG_EN
      to_exp = (i >= 64);
`else
      to_exp = 1'b0;
`endif
      if (i == 0 || i == 63 || i == 64 || i == 69)
        expect_out($sformatf("watchdog_c%0d", i), C_SID | C_TO, 1, 0, '0, '0, 0, to_exp);
      step();
    end
    idle(); flush = 1;
    step();
    idle();
    expect_out("watchdog_flushed", C_SID | C_TO | C_BUSY, 0, 0, '1, '0, 0, 0);
    step();
    step();

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
